modexp_ctrl: RTL

- Sequencer that computes x^e mod m by issuing a chain of Montgomery multiplications to the existing 512-bit Montgomery multiplier.
- Sits directly upstream of the multiplier: drives its start and operand inputs, consumes its result/done, and accumulates between operations.
- Performs the to-Montgomery conversion, left-to-right square-and-multiply, and the from-Montgomery conversion.
- Presents a single start/done interface to the RSA top level.

---
 rtl/modexp_pkg.sv | 22 ++
 rtl/modexp_ctrl_if.sv | 36 +++
 rtl/modexp_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/modexp_pkg.sv
// rtl/modexp_pkg.sv - shared width defaults and state/op encodings for the modexp sequencer
package modexp_pkg;

    localparam int N_DEF      = 512;
    localparam int ELEN_W_DEF = 10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TOMONT,
        SQ,
        MUL,
        FROMMONT
    } op_t;

endpackage

// File: rtl/modexp_ctrl_if.sv
// rtl/modexp_ctrl_if.sv - host start/done bundle plus Montgomery multiplier handshake for modexp_ctrl
interface modexp_ctrl_if
    import modexp_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ELEN_W = ELEN_W_DEF
);

    logic              start;
    logic [N-1:0]      in_x;
    logic [N-1:0]      in_e;
    logic [ELEN_W-1:0] in_e_len;
    logic [N-1:0]      in_m;
    logic [N-1:0]      in_r;
    logic [N-1:0]      in_r2;
    logic [N-1:0]      result;
    logic              done;
    logic              busy;
    logic              mm_start;
    logic [N-1:0]      mm_in_a;
    logic [N-1:0]      mm_in_b;
    logic [N-1:0]      mm_in_m;
    logic [N-1:0]      mm_result;
    logic              mm_done;

    modport slave (
        input  start, in_x, in_e, in_e_len, in_m, in_r, in_r2, mm_result, mm_done,
        output result, done, busy, mm_start, mm_in_a, mm_in_b, mm_in_m
    );

    modport master (
        output start, in_x, in_e, in_e_len, in_m, in_r, in_r2, mm_result, mm_done,
        input  result, done, busy, mm_start, mm_in_a, mm_in_b, mm_in_m
    );

endinterface

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - left-to-right square-and-multiply sequencer driving an external Montgomery multiplier
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ELEN_W = ELEN_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    modexp_ctrl_if.slave bus
);

    localparam int           IW  = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t            state, state_nx;
    op_t               op, op_nx;
    logic [ELEN_W-1:0] idx, idx_nx;
    logic [N-1:0]      x_q, e_q, m_q, r2_q, xm, acc, res_q;
    logic [N-1:0]      opa, opb;
    logic              ebit;
    logic              idx_zero;

    assign ebit     = e_q[idx[IW-1:0]];
    assign idx_zero = (idx == '0);

    // idx is tested before it is decremented, so it never wraps below zero
    always_comb begin
        state_nx = state;
        op_nx    = op;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = ISSUE;
                    op_nx    = TOMONT;
                    idx_nx   = bus.in_e_len;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (bus.mm_done) state_nx = NEXT;
            end
            NEXT: begin
                state_nx = ISSUE;
                if (op == FROMMONT) begin
                    state_nx = DONE;
                end else if (op == SQ && ebit) begin
                    op_nx = MUL;
                end else if (idx_zero) begin
                    op_nx = FROMMONT;
                end else begin
                    idx_nx = idx - 1'b1;
                    op_nx  = SQ;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands come straight from registers that are frozen during WAIT
    always_comb begin
        opa = '0;
        opb = '0;
        case (op)
            TOMONT:   begin opa = x_q; opb = r2_q; end
            SQ:       begin opa = acc; opb = acc;  end
            MUL:      begin opa = acc; opb = xm;   end
            FROMMONT: begin opa = acc; opb = ONE;  end
            default:  begin opa = '0;  opb = '0;   end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op    <= TOMONT;
            idx   <= '0;
            x_q   <= '0;
            e_q   <= '0;
            m_q   <= '0;
            r2_q  <= '0;
            xm    <= '0;
            acc   <= '0;
            res_q <= '0;
        end else begin
            state <= state_nx;
            op    <= op_nx;
            idx   <= idx_nx;
            if (state == IDLE && bus.start) begin
                x_q  <= bus.in_x;
                e_q  <= bus.in_e;
                m_q  <= bus.in_m;
                r2_q <= bus.in_r2;
                acc  <= bus.in_r;
            end
            if (state == WAIT && bus.mm_done) begin
                if (op == TOMONT) xm <= bus.mm_result;
                else              acc <= bus.mm_result;
            end
            if (state == NEXT && op == FROMMONT) res_q <= acc;
        end
    end

    assign bus.mm_start = (state == ISSUE);
    assign bus.mm_in_a  = opa;
    assign bus.mm_in_b  = opb;
    assign bus.mm_in_m  = m_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.result   = res_q;

endmodule
